// File: rtl/bram_port_initiator.sv
// Bridges a req/gnt/rvalid core data port onto a single BRAM port with fixed read latency.
// Define KUUGA_BRAM_BYTE_WRITE_EN when the BRAM has byte write enables; otherwise partial writes use read-modify-write.
module bram_port_initiator #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  bram_clk_a,
    output logic                  bram_rst_a,
    output logic                  bram_en_a,
    output logic [3:0]            bram_we_a,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    output logic [31:0]           bram_wrdata_a,
    input  logic [31:0]           bram_rddata_a
);

    localparam int unsigned WAIT_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RMW_RD   = 2'd1,
        RMW_WAIT = 2'd2,
        RMW_WR   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [READ_LATENCY-1:0] sr_valid_q, sr_read_q;
    logic                    grant_c;
    logic                    rmw_needed_c;
    logic [31:0]             merged_c;
    logic                    unused_c;

    assign bram_clk_a  = clk;
    assign bram_rst_a  = ~rst_n;
    assign bram_addr_a = {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_c    = ^{data_addr_i[31:ADDR_WIDTH], data_addr_i[1:0]};

`ifdef KUUGA_BRAM_BYTE_WRITE_EN
    assign rmw_needed_c = 1'b0;
`else
    assign rmw_needed_c = data_we_i && (data_be_i != 4'hF) && (data_be_i != 4'h0);
`endif

    // New bytes where enabled, bytes read back from the BRAM elsewhere
    always_comb begin
        merged_c = bram_rddata_a;
        for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
                merged_c[8*b +: 8] = data_wdata_i[8*b +: 8];
            end
        end
    end

    // Next state and BRAM port drive; everything forced quiet while in reset
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        grant_c       = 1'b0;
        bram_en_a     = 1'b0;
        bram_we_a     = 4'h0;
        bram_wrdata_a = data_wdata_i;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (data_req_i) begin
                        if (rmw_needed_c) begin
                            state_d = RMW_RD;
                        end else begin
                            grant_c = 1'b1;
                            if (data_we_i) begin
                                bram_en_a = |data_be_i;
                                bram_we_a = data_be_i;
                            end else begin
                                bram_en_a = 1'b1;
                            end
                        end
                    end
                end
                RMW_RD: begin
                    bram_en_a = 1'b1;
                    if (READ_LATENCY == 1) begin
                        state_d = RMW_WR;
                    end else begin
                        state_d = RMW_WAIT;
                        wait_d  = WAIT_W'(READ_LATENCY - 1);
                    end
                end
                RMW_WAIT: begin
                    if (wait_q == WAIT_W'(1)) begin
                        state_d = RMW_WR;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                RMW_WR: begin
                    grant_c       = 1'b1;
                    bram_en_a     = 1'b1;
                    bram_we_a     = 4'hF;
                    bram_wrdata_a = merged_c;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_gnt_o = grant_c;

    // State register and in-order response pipeline, one slot per cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            sr_valid_q <= '0;
            sr_read_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            sr_valid_q <= (sr_valid_q << 1) | READ_LATENCY'(grant_c);
            sr_read_q  <= (sr_read_q << 1) | READ_LATENCY'(grant_c & ~data_we_i);
        end
    end

    assign data_rvalid_o = sr_valid_q[READ_LATENCY-1];
    assign data_rdata_o  = (sr_valid_q[READ_LATENCY-1] && sr_read_q[READ_LATENCY-1]) ? bram_rddata_a : 32'h0;

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed bench for bram_port_initiator with a behavioural 2-cycle-latency BRAM.
module tb_bram_port_initiator;

    logic        clk, rst_n;
    logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0]  data_be_i;
    logic        bram_clk_a, bram_rst_a, bram_en_a;
    logic [3:0]  bram_we_a;
    logic [15:0] bram_addr_a;
    logic [31:0] bram_wrdata_a, bram_rddata_a;

    logic [31:0] mem [0:255];
    logic [31:0] pipe0, pipe1;
    int          checks = 0;
    int          errors = 0;
    logic        ev [2];
    logic [31:0] ed [2];

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_gnt;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [31:0] exp_rdata;
        logic        chk_wd;
        logic [31:0] exp_wd;
    } vec_t;

    bram_port_initiator #(.ADDR_WIDTH(16), .READ_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .bram_clk_a(bram_clk_a), .bram_rst_a(bram_rst_a), .bram_en_a(bram_en_a),
        .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a), .bram_wrdata_a(bram_wrdata_a),
        .bram_rddata_a(bram_rddata_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM, output holds when disabled, two register stages
    always @(posedge clk) begin
        if (bram_en_a) begin
            for (int b = 0; b < 4; b++)
                if (bram_we_a[b]) mem[bram_addr_a[9:2]][8*b +: 8] <= bram_wrdata_a[8*b +: 8];
            pipe0 <= mem[bram_addr_a[9:2]];
        end
        pipe1 <= pipe0;
    end
    assign bram_rddata_a = pipe1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input logic g,
                                input logic en, input logic [3:0] wexp, input logic [31:0] rd,
                                input logic cw, input logic [31:0] ewd);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.be = be; v.wdata = wd;
        v.exp_gnt = g; v.exp_en = en; v.exp_we = wexp; v.exp_rdata = rd;
        v.chk_wd = cw; v.exp_wd = ewd;
        return v;
    endfunction

    function automatic vec_t rd(input logic [31:0] addr, input logic [31:0] data);
        return mk(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b1, 1'b1, 4'h0, data, 1'b0, 32'h0);
    endfunction

    function automatic vec_t idl();
        return mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0);
    endfunction

    // One cycle: drive at posedge+1, check at negedge, advance expected response line at posedge
    task automatic step(input vec_t v, input string tag);
        data_req_i   = v.req;
        data_we_i    = v.we;
        data_addr_i  = v.addr;
        data_be_i    = v.be;
        data_wdata_i = v.wdata;
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(data_gnt_o), 32'(v.exp_gnt));
        chk({tag, ".en"}, 32'(bram_en_a), 32'(v.exp_en));
        chk({tag, ".we"}, 32'(bram_we_a), 32'(v.exp_we));
        chk({tag, ".rvalid"}, 32'(data_rvalid_o), 32'(ev[1]));
        chk({tag, ".rdata"}, data_rdata_o, ev[1] ? ed[1] : 32'h0);
        if (v.req) chk({tag, ".addr"}, 32'(bram_addr_a), 32'({v.addr[15:2], 2'b00}));
        if (v.chk_wd) chk({tag, ".wrdata"}, bram_wrdata_a, v.exp_wd);
        @(posedge clk);
        ev[1] = ev[0]; ed[1] = ed[0];
        ev[0] = v.exp_gnt; ed[0] = v.exp_rdata;
        #1;
    endtask

    vec_t tbl[$];
    vec_t rmw[$];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[2] = 32'hDEAD_BEEF;
        mem[3] = 32'h0BAD_F00D;
        pipe0 = 32'h0; pipe1 = 32'h0;
        ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = 32'h0; ed[1] = 32'h0;
        rst_n = 1'b0; data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h8;
        data_be_i = 4'h0; data_wdata_i = 32'h0;

        #3;
        chk("rst.gnt", 32'(data_gnt_o), 32'h0);
        chk("rst.en", 32'(bram_en_a), 32'h0);
        chk("rst.we", 32'(bram_we_a), 32'h0);
        chk("rst.rvalid", 32'(data_rvalid_o), 32'h0);
        chk("rst.rdata", data_rdata_o, 32'h0);
        chk("rst.bram_rst", 32'(bram_rst_a), 32'h1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; data_req_i = 1'b0;
        #1;
        chk("rel.bram_rst", 32'(bram_rst_a), 32'h0);
        @(posedge clk); #1;

        // Reads, back-to-back, full write, read-back, empty write, aliased address
        tbl.push_back(rd(32'h0000_0008, 32'hDEAD_BEEF));
        tbl.push_back(rd(32'h0000_0000, 32'hA500_0000));
        tbl.push_back(rd(32'h0000_0004, 32'hA500_0001));
        tbl.push_back(rd(32'h0000_0008, 32'hDEAD_BEEF));
        tbl.push_back(rd(32'h0000_000C, 32'h0BAD_F00D));
        tbl.push_back(idl());
        tbl.push_back(mk(1'b1, 1'b1, 32'h10, 4'hF, 32'h1234_5678, 1'b1, 1'b1, 4'hF, 32'h0, 1'b1, 32'h1234_5678));
        tbl.push_back(rd(32'h0000_0010, 32'h1234_5678));
        tbl.push_back(mk(1'b1, 1'b1, 32'h14, 4'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0));
        tbl.push_back(rd(32'h0001_0013, 32'h1234_5678));
        tbl.push_back(idl());
        tbl.push_back(idl());
        tbl.push_back(idl());
        foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

        // Partial write; a read granted just before must still respond on schedule
        mem[4] = 32'hAABB_CCDD;
        rmw.push_back(rd(32'h0000_0008, 32'hDEAD_BEEF));
`ifdef KUUGA_BRAM_BYTE_WRITE_EN
        rmw.push_back(mk(1'b1, 1'b1, 32'h10, 4'h1, 32'h0000_00EE, 1'b1, 1'b1, 4'h1, 32'h0, 1'b1, 32'h0000_00EE));
`else
        rmw.push_back(mk(1'b1, 1'b1, 32'h10, 4'h1, 32'h0000_00EE, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0));
        rmw.push_back(mk(1'b1, 1'b1, 32'h10, 4'h1, 32'h0000_00EE, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0));
        rmw.push_back(mk(1'b1, 1'b1, 32'h10, 4'h1, 32'h0000_00EE, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0));
        rmw.push_back(mk(1'b1, 1'b1, 32'h10, 4'h1, 32'h0000_00EE, 1'b1, 1'b1, 4'hF, 32'h0, 1'b1, 32'hAABB_CCEE));
`endif
        rmw.push_back(idl());
        rmw.push_back(idl());
        rmw.push_back(rd(32'h0000_0010, 32'hAABB_CCEE));
        rmw.push_back(idl());
        rmw.push_back(idl());
        rmw.push_back(idl());
        foreach (rmw[i]) step(rmw[i], $sformatf("rmw%0d", i));
        chk("rmw.mem", mem[4], 32'hAABB_CCEE);

        // Reset mid-operation: outputs drop at once, nothing written or answered afterwards
`ifdef KUUGA_BRAM_BYTE_WRITE_EN
        step(rd(32'h0000_0008, 32'hDEAD_BEEF), "ra0");
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h8;
`else
        step(mk(1'b1, 1'b1, 32'h10, 4'h1, 32'h0000_0055, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0), "ra0");
        step(mk(1'b1, 1'b1, 32'h10, 4'h1, 32'h0000_0055, 1'b0, 1'b1, 4'h0, 32'h0, 1'b0, 32'h0), "ra1");
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra.gnt", 32'(data_gnt_o), 32'h0);
        chk("ra.en", 32'(bram_en_a), 32'h0);
        chk("ra.we", 32'(bram_we_a), 32'h0);
        chk("ra.rvalid", 32'(data_rvalid_o), 32'h0);
        chk("ra.rdata", data_rdata_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; data_req_i = 1'b0;
        ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = 32'h0; ed[1] = 32'h0;
        for (int i = 0; i < 4; i++) step(idl(), $sformatf("post%0d", i));
        chk("ra.mem", mem[4], 32'hAABB_CCEE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
